// File: rtl/riscv_defs.sv
// Shared RV32I definitions: data width, privilege levels and the prefetch decode-queue entry.
package riscv_defs;

  localparam int unsigned RV_XLEN = 32;

  localparam logic [1:0] PRV_U = 2'b00;
  localparam logic [1:0] PRV_S = 2'b01;
  localparam logic [1:0] PRV_M = 2'b11;

  typedef struct packed {
    logic               sofid;
    logic               ferr;
    logic [RV_XLEN-1:0] pc;
    logic [RV_XLEN-1:0] ins;
  } pfu_entry_t;

  localparam int unsigned PFU_ENTRY_W = $bits(pfu_entry_t);

endpackage

// File: rtl/pfu_fifo.sv
// Synchronous FIFO with flush, occupancy count and a combinational head output.
module pfu_fifo #(
  parameter int unsigned Width          = 32,
  parameter int unsigned C_FIFO_DEPTH_X = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  input  logic [Width-1:0]        din_i,
  output logic [Width-1:0]        head_o,
  output logic [C_FIFO_DEPTH_X:0] count_o
);

  localparam int unsigned Depth = 1 << C_FIFO_DEPTH_X;
  localparam int unsigned CntW  = C_FIFO_DEPTH_X + 1;
  localparam logic [C_FIFO_DEPTH_X-1:0] PtrOne = 1;

  logic [Width-1:0]          mem_q [Depth];
  logic [C_FIFO_DEPTH_X-1:0] wptr_q, rptr_q;
  logic [CntW-1:0]           count_q;
  logic                      empty, full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign do_pop  = pop_i & ~empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push_i & (~full | do_pop);

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrOne;
      if (do_pop)  rptr_q <= rptr_q + PtrOne;
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/rv_pfu.sv
// RV32I instruction prefetch unit: credit-limited sequential fetch, in-order response queue, vectoring.
// Define RV_PFU_ASSERT_EN to enable simulation checks on alignment, overflow and stray responses.
module rv_pfu
  import riscv_defs::*;
#(
  parameter int unsigned C_BUS_SZX      = 5,
  parameter int unsigned C_FIFO_DEPTH_X = 2,
  parameter logic [31:0] C_RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clk_en_i,
  input  logic        ireqready_i,
  output logic        ireqvalid_o,
  output logic [1:0]  ireqhpl_o,
  output logic [31:0] ireqaddr_o,
  output logic        irspready_o,
  input  logic        irspvalid_i,
  input  logic        irsprerr_i,
  input  logic [31:0] irspdata_i,
  output logic        ids_dav_o,
  input  logic        ids_ack_i,
  output logic        ids_sofid_o,
  output logic [31:0] ids_ins_o,
  output logic        ids_ferr_o,
  output logic [31:0] ids_pc_o,
  output logic        hvec_pc_ready_o,
  input  logic        hvec_pc_wr_i,
  input  logic [31:0] hvec_pc_din_i,
  input  logic [1:0]  exs_hpl_i
);

  localparam int unsigned Depth = 1 << C_FIFO_DEPTH_X;
  localparam int unsigned CntW  = C_FIFO_DEPTH_X + 1;
  localparam logic [31:0] Stride = 32'd1 << (C_BUS_SZX - 3);

  logic [31:0]     pc_q, pc_d;
  logic            sofid_q, sofid_d;
  logic [CntW-1:0] discard_q, discard_d;
  logic [CntW-1:0] outst, occ, outst_nxt;
  logic [CntW:0]   credit;
  logic            req_hs, rsp, vec, dec_push, dec_pop;
  logic [31:0]     pend_head;
  pfu_entry_t      dec_din, dec_head;

  assign hvec_pc_ready_o = ~reset_i;
  assign irspready_o     = 1'b1;

  // Reserve a decode slot for every request in flight so responses never overflow the queue.
  assign credit      = {1'b0, occ} + {1'b0, outst};
  assign ireqvalid_o = ~reset_i & (credit < (CntW + 1)'(Depth));
  assign ireqaddr_o  = pc_q;
  assign ireqhpl_o   = reset_i ? PRV_U : exs_hpl_i;

  assign req_hs    = ireqvalid_o & ireqready_i & clk_en_i;
  assign rsp       = irspvalid_i & clk_en_i;
  assign vec       = hvec_pc_wr_i & hvec_pc_ready_o & clk_en_i;
  assign dec_push  = rsp & (discard_q == '0);
  assign dec_pop   = ids_ack_i & clk_en_i & ~vec;
  assign outst_nxt = outst + CntW'(req_hs) - CntW'(rsp);

  always_comb begin
    pc_d      = pc_q;
    sofid_d   = sofid_q;
    discard_d = discard_q;
    if (req_hs) pc_d = pc_q + Stride;
    if (dec_push) sofid_d = 1'b0;
    if (rsp && discard_q != '0) discard_d = discard_q - CntW'(1);
    // Everything still in flight after this cycle belongs to the abandoned stream.
    if (vec) begin
      pc_d      = hvec_pc_din_i & ~32'h3;
      sofid_d   = 1'b1;
      discard_d = outst_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q      <= C_RESET_VECTOR;
      sofid_q   <= 1'b1;
      discard_q <= '0;
    end else if (clk_en_i) begin
      pc_q      <= pc_d;
      sofid_q   <= sofid_d;
      discard_q <= discard_d;
    end
  end

  pfu_fifo #(
    .Width          (32),
    .C_FIFO_DEPTH_X (C_FIFO_DEPTH_X)
  ) u_pend_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (req_hs),
    .pop_i   (rsp),
    .flush_i (1'b0),
    .din_i   (pc_q),
    .head_o  (pend_head),
    .count_o (outst)
  );

  assign dec_din = '{sofid: sofid_q, ferr: irsprerr_i, pc: pend_head, ins: irspdata_i};

  pfu_fifo #(
    .Width          (PFU_ENTRY_W),
    .C_FIFO_DEPTH_X (C_FIFO_DEPTH_X)
  ) u_dec_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (dec_push),
    .pop_i   (dec_pop),
    .flush_i (vec),
    .din_i   (dec_din),
    .head_o  (dec_head),
    .count_o (occ)
  );

  assign ids_dav_o   = ~reset_i & (occ != '0);
  assign ids_sofid_o = ids_dav_o & dec_head.sofid;
  assign ids_ferr_o  = ids_dav_o & dec_head.ferr;
  assign ids_pc_o    = ids_dav_o ? dec_head.pc : '0;
  assign ids_ins_o   = ids_dav_o ? dec_head.ins : '0;

`ifdef RV_PFU_ASSERT_EN
  a_addr_aligned: assert property (@(posedge clk_i) disable iff (reset_i)
    ireqvalid_o |-> (ireqaddr_o[1:0] == 2'b00))
    else $error("rv_pfu: misaligned fetch address %h", ireqaddr_o);

  a_dec_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(dec_push && occ == CntW'(Depth) && !dec_pop))
    else $error("rv_pfu: decode queue written while full");

  a_rsp_expected: assert property (@(posedge clk_i) disable iff (reset_i)
    rsp |-> (outst != '0))
    else $error("rv_pfu: response with nothing outstanding");
`else
  // Checks compiled out; behaviour is identical.
`endif

endmodule

// File: tb/tb_rv_pfu.sv
// Self-checking bench for rv_pfu: directed table, random stream with scoreboard, vector and stall cases.
`timescale 1ns/1ps
module tb_rv_pfu;

  typedef struct packed {
    logic [31:0] pc;
    logic        sofid;
    logic        ferr;
  } exp_t;

  typedef struct {
    logic        rdy;
    logic        rsp;
    logic        ack;
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic        exp_dav;
    logic [31:0] exp_pc;
  } row_t;

  logic        clk = 1'b0;
  logic        reset_i, clk_en_i, ireqready_i, ireqvalid_o, irspready_o;
  logic [1:0]  ireqhpl_o, exs_hpl_i;
  logic [31:0] ireqaddr_o, irspdata_i, ids_ins_o, ids_pc_o, hvec_pc_din_i;
  logic        irspvalid_i, irsprerr_i, ids_dav_o, ids_ack_i, ids_sofid_o, ids_ferr_o;
  logic        hvec_pc_ready_o, hvec_pc_wr_i;

  rv_pfu dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .clk_en_i        (clk_en_i),
    .ireqready_i     (ireqready_i),
    .ireqvalid_o     (ireqvalid_o),
    .ireqhpl_o       (ireqhpl_o),
    .ireqaddr_o      (ireqaddr_o),
    .irspready_o     (irspready_o),
    .irspvalid_i     (irspvalid_i),
    .irsprerr_i      (irsprerr_i),
    .irspdata_i      (irspdata_i),
    .ids_dav_o       (ids_dav_o),
    .ids_ack_i       (ids_ack_i),
    .ids_sofid_o     (ids_sofid_o),
    .ids_ins_o       (ids_ins_o),
    .ids_ferr_o      (ids_ferr_o),
    .ids_pc_o        (ids_pc_o),
    .hvec_pc_ready_o (hvec_pc_ready_o),
    .hvec_pc_wr_i    (hvec_pc_wr_i),
    .hvec_pc_din_i   (hvec_pc_din_i),
    .exs_hpl_i       (exs_hpl_i)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  exp_t        sb_q[$];
  logic [31:0] bus_q[$];
  int          fifo_cnt, outst_m, drop_m;
  logic        first_m;
  logic [31:0] exp_pc_m, err_addr;
  row_t        tbl[9];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic tick(input logic rdy, input logic rsp, input logic ack,
                      input logic vec, input logic [31:0] vaddr);
    logic        hs, rsp_go;
    logic [31:0] a;
    exp_t        e;
    chk1("ireqvalid", ireqvalid_o, (fifo_cnt + outst_m) < 4);
    if (ireqvalid_o) chk32("ireqaddr", ireqaddr_o, exp_pc_m);
    chk1("ids_dav", ids_dav_o, fifo_cnt != 0);
    ireqready_i   = rdy;
    ids_ack_i     = ack;
    hvec_pc_wr_i  = vec;
    hvec_pc_din_i = vaddr;
    rsp_go        = rsp && (bus_q.size() > 0);
    irspvalid_i   = rsp_go;
    irspdata_i    = 32'h0;
    irsprerr_i    = 1'b0;
    if (rsp_go) begin
      a          = bus_q.pop_front();
      irspdata_i = a;
      irsprerr_i = (a == err_addr);
    end
    #1;
    hs = ireqvalid_o && rdy;
    if (ack && fifo_cnt > 0 && !vec) begin
      e = sb_q.pop_front();
      chk32("ids_pc", ids_pc_o, e.pc);
      chk32("ids_ins", ids_ins_o, e.pc);
      chk1("ids_sofid", ids_sofid_o, e.sofid);
      chk1("ids_ferr", ids_ferr_o, e.ferr);
      fifo_cnt--;
    end
    if (rsp_go) begin
      outst_m--;
      if (drop_m > 0) drop_m--;
      else fifo_cnt++;
    end
    if (hs) begin
      sb_q.push_back('{pc: exp_pc_m, sofid: first_m, ferr: (exp_pc_m == err_addr)});
      first_m = 1'b0;
      outst_m++;
      bus_q.push_back(ireqaddr_o);
      exp_pc_m = exp_pc_m + 32'd4;
    end
    if (vec) begin
      sb_q.delete();
      fifo_cnt = 0;
      drop_m   = outst_m;
      first_m  = 1'b1;
      exp_pc_m = vaddr & ~32'h3;
    end
    @(posedge clk);
    @(negedge clk);
    ids_ack_i    = 1'b0;
    hvec_pc_wr_i = 1'b0;
    irspvalid_i  = 1'b0;
    irsprerr_i   = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((outst_m > 0 || fifo_cnt > 0) && n < 100) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end
    chk1("drain_done", (outst_m == 0) && (fifo_cnt == 0), 1'b1);
  endtask

  task automatic rand_run(input int n, input int vec_pct);
    logic        v;
    logic [31:0] va;
    for (int i = 0; i < n; i++) begin
      v  = ($urandom_range(0, 99) < vec_pct);
      va = 32'h2000 + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           v, va);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a0, p0;
    logic        v0, d0;

    reset_i = 1'b1;      clk_en_i = 1'b1;     ireqready_i = 1'b0; irspvalid_i = 1'b0;
    irsprerr_i = 1'b0;   irspdata_i = 32'h0;  ids_ack_i = 1'b0;   hvec_pc_wr_i = 1'b0;
    hvec_pc_din_i = 32'h0; exs_hpl_i = 2'b11;
    fifo_cnt = 0; outst_m = 0; drop_m = 0; first_m = 1'b1; exp_pc_m = 32'h0; err_addr = 32'h8;

    // Startup with ack held low: four requests fill the credit, then the unit stalls.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h04, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h08, 1'b1, 32'h0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h4};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h14, 1'b1, 32'h4};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_valid", ireqvalid_o, 1'b0);
    chk1("rst_dav", ids_dav_o, 1'b0);
    chk1("rst_sofid", ids_sofid_o, 1'b0);
    chk1("rst_ferr", ids_ferr_o, 1'b0);
    chk32("rst_ins", ids_ins_o, 32'h0);
    chk32("rst_pc", ids_pc_o, 32'h0);
    chk32("rst_hpl", {30'h0, ireqhpl_o}, 32'h0);
    chk1("rst_hvec_ready", hvec_pc_ready_o, 1'b0);
    chk1("rspready", irspready_o, 1'b1);
    reset_i = 1'b0;
    #1;
    chk1("hvec_ready", hvec_pc_ready_o, 1'b1);
    chk32("hpl", {30'h0, ireqhpl_o}, 32'h3);

    for (int i = 0; i < 9; i++) begin
      chk1($sformatf("tbl%0d_valid", i), ireqvalid_o, tbl[i].exp_valid);
      if (tbl[i].exp_valid) chk32($sformatf("tbl%0d_addr", i), ireqaddr_o, tbl[i].exp_addr);
      chk1($sformatf("tbl%0d_dav", i), ids_dav_o, tbl[i].exp_dav);
      if (tbl[i].exp_dav) chk32($sformatf("tbl%0d_pc", i), ids_pc_o, tbl[i].exp_pc);
      tick(tbl[i].rdy, tbl[i].rsp, tbl[i].ack, 1'b0, 32'h0);
    end

    // Random stream; the entry at 0x8 carries a bus error.
    rand_run(300, 0);

    // Freeze with clk_en low while ack is asserted; nothing may move.
    repeat (4) tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    a0 = ireqaddr_o; v0 = ireqvalid_o; d0 = ids_dav_o; p0 = ids_pc_o;
    clk_en_i = 1'b0; ids_ack_i = 1'b1; ireqready_i = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      chk32("cken_addr", ireqaddr_o, a0);
      chk1("cken_valid", ireqvalid_o, v0);
      chk1("cken_dav", ids_dav_o, d0);
      chk32("cken_pc", ids_pc_o, p0);
    end
    ids_ack_i = 1'b0; clk_en_i = 1'b1;
    rand_run(100, 0);
    drain();

    // Two requests in flight, then vector: both responses must be dropped.
    tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h1003);
    chk1("vec_valid", ireqvalid_o, 1'b1);
    chk32("vec_addr", ireqaddr_o, 32'h1000);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk1("vec_discard_dav", ids_dav_o, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk32("vec_pc0", ids_pc_o, 32'h1000);
    chk1("vec_sofid0", ids_sofid_o, 1'b1);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk32("vec_pc1", ids_pc_o, 32'h1004);
    chk1("vec_sofid1", ids_sofid_o, 1'b0);
    drain();

    // Random vectors landing on handshakes, responses and acks.
    rand_run(400, 4);
    drain();

    // Address wrap past 0xFFFFFFFC.
    err_addr = 32'hFFFF_FFFF;
    tick(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF4);
    rand_run(60, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
